// File: rtl/nios_mul_cell_seq_if.sv
`timescale 1ns/1ps
// Request/response port of the multiply sequencer.
// The requester (CPU execute stage) uses the master modport and the sequencer uses the slave modport.
interface nios_mul_cell_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;

    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/nios_mul_cell_seq.sv
`timescale 1ns/1ps
// Sequencer for the 3-product 16x16 multiplier cell: one 32x32 unsigned multiply in flight at a time.
// Define NIOS_MUL_SEQ_MULX_EN to add MULXUU (high word) through a second cell pass; otherwise only MUL is built.
module nios_mul_cell_seq (
    input  logic               clk,
    input  logic               reset_n,
    nios_mul_cell_seq_if.slave bus,
    output logic               busy,
    output logic [31:0]        cell_src1,
    output logic [31:0]        cell_src2,
    output logic               cell_en,
    input  logic [31:0]        cell_p1,
    input  logic [31:0]        cell_p2,
    input  logic [31:0]        cell_p3
);

`ifdef NIOS_MUL_SEQ_MULX_EN
    typedef enum logic [2:0] {IDLE, ISSUE1, CAPT1, CAPT2, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE1, CAPT1, RESP} state_t;
`endif

    state_t      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        busy_q;
    logic        cell_en_q;
    logic [31:0] cell_src1_q;
    logic [31:0] cell_src2_q;
    logic        accept;

`ifdef NIOS_MUL_SEQ_MULX_EN
    logic        op_q;
    logic [15:0] a_hi_q;
    logic [15:0] b_hi_q;
    logic [32:0] mid;
    logic [48:0] low_d;
    logic [48:0] low_q;
    logic [31:0] hi_d;
    logic [31:0] hi_q;

    // Keep the full 49-bit low sum so its carries (bits 48:32) feed the high word.
    always_comb begin
        mid   = {1'b0, cell_p2} + {1'b0, cell_p3};
        low_d = {17'b0, cell_p1} + {mid, 16'b0};
        hi_d  = cell_p1 + {15'b0, low_q[48:32]};
    end
`else
    logic [31:0] low_d;
    logic [31:0] low_q;

    always_comb begin
        low_d = cell_p1 + ((cell_p2 + cell_p3) << 16);
    end
`endif

    assign accept = bus.req_valid && req_ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cell_en_q   <= 1'b0;
            cell_src1_q <= '0;
            cell_src2_q <= '0;
            low_q       <= '0;
`ifdef NIOS_MUL_SEQ_MULX_EN
            op_q        <= 1'b0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            hi_q        <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cell_src1_q <= bus.req_src1;
                        cell_src2_q <= bus.req_src2;
                        cell_en_q   <= 1'b1;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef NIOS_MUL_SEQ_MULX_EN
                        op_q        <= bus.req_op;
                        a_hi_q      <= bus.req_src1[31:16];
                        b_hi_q      <= bus.req_src2[31:16];
`endif
                        state_q     <= ISSUE1;
                    end
                end

                // Outputs are registered, so the second-pass operands are loaded here to appear during CAPT1.
                ISSUE1: begin
`ifdef NIOS_MUL_SEQ_MULX_EN
                    if (op_q) begin
                        cell_src1_q <= {16'b0, a_hi_q};
                        cell_src2_q <= {16'b0, b_hi_q};
                        cell_en_q   <= 1'b1;
                    end else begin
                        cell_en_q   <= 1'b0;
                    end
`else
                    cell_en_q <= 1'b0;
`endif
                    state_q <= CAPT1;
                end

                CAPT1: begin
                    low_q     <= low_d;
                    cell_en_q <= 1'b0;
`ifdef NIOS_MUL_SEQ_MULX_EN
                    if (op_q) begin
                        state_q <= CAPT2;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
`else
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
`endif
                end

`ifdef NIOS_MUL_SEQ_MULX_EN
                // Second pass: cell_p1 now holds A_hi*B_hi.
                CAPT2: begin
                    hi_q        <= hi_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
`endif

                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign busy          = busy_q;
    assign cell_en       = cell_en_q;
    assign cell_src1     = cell_src1_q;
    assign cell_src2     = cell_src2_q;

`ifdef NIOS_MUL_SEQ_MULX_EN
    assign bus.rsp_result = op_q ? hi_q : low_q[31:0];
`else
    assign bus.rsp_result = low_q;
`endif

endmodule

// File: tb/tb_nios_mul_cell_seq.sv
`timescale 1ns/1ps
// Directed bench for nios_mul_cell_seq with a behavioural model of the 3-product multiplier cell.
// Expected values follow NIOS_MUL_SEQ_MULX_EN when it is defined for the build.
module tb_nios_mul_cell_seq;

`ifdef NIOS_MUL_SEQ_MULX_EN
    localparam bit MULX = 1'b1;
`else
    localparam bit MULX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        busy;
    logic        cell_en;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic [31:0] cell_p1 = '0;
    logic [31:0] cell_p2 = '0;
    logic [31:0] cell_p3 = '0;

    int total = 0;
    int bad   = 0;

    nios_mul_cell_seq_if bus();

    nios_mul_cell_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .busy      (busy),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3)
    );

    always #5 clk = ~clk;

    // Multiplier cell: partials registered on clk while enabled.
    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= 32'(cell_src1[15:0]) * 32'(cell_src2[15:0]);
            cell_p2 <= 32'(cell_src1[15:0]) * 32'(cell_src2[31:16]);
            cell_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
        end
    end

    // Issues one request from IDLE and reports latency (cycles after accept), result and per-cycle cell_en.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic op,
                         output int lat, output logic [31:0] res, output logic [31:0] enMask);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_src1  = a;
        bus.req_src2  = b;
        bus.req_op    = op;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat    = -1;
        res    = '0;
        enMask = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (cell_en) enMask[k] = 1'b1;
            if (bus.rsp_valid) begin
                lat = k;
                res = bus.rsp_result;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        total++; if (bus.rsp_result !== 32'h0) begin bad++; $display("[TB] FAIL reset_rsp_result: got %h want 0", bus.rsp_result); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (cell_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_cell_en: got %b want 0", cell_en); end
        total++; if (cell_src1 !== 32'h0) begin bad++; $display("[TB] FAIL reset_cell_src1: got %h want 0", cell_src1); end
        total++; if (cell_src2 !== 32'h0) begin bad++; $display("[TB] FAIL reset_cell_src2: got %h want 0", cell_src2); end
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_mul_basic();
        int lat;
        logic [31:0] res;
        logic [31:0] mask;
        runOp(32'h0000_0003, 32'h0000_0005, 1'b0, lat, res, mask);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL basic_latency: got %0d want 3", lat); end
        total++; if (res !== 32'h0000_000F) begin bad++; $display("[TB] FAIL basic_result: got %h want 0000000f", res); end
        total++; if (mask !== 32'h2) begin bad++; $display("[TB] FAIL basic_cell_en: got %h want 00000002", mask); end
    endtask

    task automatic test_all_ones();
        int lat;
        logic [31:0] res;
        logic [31:0] mask;
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, res, mask);
        total++; if (lat !== (MULX ? 4 : 3)) begin bad++; $display("[TB] FAIL ones_hi_latency: got %0d want %0d", lat, MULX ? 4 : 3); end
        total++; if (res !== (MULX ? 32'hFFFF_FFFE : 32'h0000_0001)) begin bad++; $display("[TB] FAIL ones_hi_result: got %h want %h", res, MULX ? 32'hFFFF_FFFE : 32'h0000_0001); end
        total++; if (mask !== (MULX ? 32'h6 : 32'h2)) begin bad++; $display("[TB] FAIL ones_hi_cell_en: got %h want %h", mask, MULX ? 32'h6 : 32'h2); end
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, res, mask);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL ones_lo_latency: got %0d want 3", lat); end
        total++; if (res !== 32'h0000_0001) begin bad++; $display("[TB] FAIL ones_lo_result: got %h want 00000001", res); end
    endtask

    task automatic test_carry();
        int lat;
        logic [31:0] res;
        logic [31:0] mask;
        runOp(32'h0001_0000, 32'h0001_0000, 1'b1, lat, res, mask);
        total++; if (res !== (MULX ? 32'h0000_0001 : 32'h0000_0000)) begin bad++; $display("[TB] FAIL carry_hi_result: got %h want %h", res, MULX ? 32'h1 : 32'h0); end
        runOp(32'h0001_0000, 32'h0001_0000, 1'b0, lat, res, mask);
        total++; if (res !== 32'h0000_0000) begin bad++; $display("[TB] FAIL carry_lo_result: got %h want 00000000", res); end
        // 0x1FFFF^2 = 0x3_FFFC_0001: exercises carries out of mid and into low[48:32].
        runOp(32'h0001_FFFF, 32'h0001_FFFF, 1'b1, lat, res, mask);
        total++; if (res !== (MULX ? 32'h0000_0003 : 32'hFFFC_0001)) begin bad++; $display("[TB] FAIL mid_hi_result: got %h want %h", res, MULX ? 32'h3 : 32'hFFFC_0001); end
        runOp(32'h8000_0000, 32'h8000_0000, 1'b1, lat, res, mask);
        total++; if (res !== (MULX ? 32'h4000_0000 : 32'h0000_0000)) begin bad++; $display("[TB] FAIL top_hi_result: got %h want %h", res, MULX ? 32'h4000_0000 : 32'h0); end
        runOp(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, lat, res, mask);
        total++; if (res !== (MULX ? 32'h0000_0001 : 32'hFFFF_FFFE)) begin bad++; $display("[TB] FAIL x2_hi_result: got %h want %h", res, MULX ? 32'h1 : 32'hFFFF_FFFE); end
        total++; if (lat !== (MULX ? 4 : 3)) begin bad++; $display("[TB] FAIL x2_hi_latency: got %0d want %0d", lat, MULX ? 4 : 3); end
    endtask

    task automatic test_backpressure();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_src1  = 32'h0001_FFFF;
        bus.req_src2  = 32'h0001_FFFF;
        bus.req_op    = 1'b0;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL stall_rsp_arrives: got %b want 1", seen); end
        // A competing request while busy must be ignored.
        bus.req_valid = 1'b1;
        bus.req_src1  = 32'h0000_0007;
        bus.req_src2  = 32'h0000_0006;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_rsp_valid: got %b want 1", bus.rsp_valid); end
            total++; if (bus.rsp_result !== 32'hFFFC_0001) begin bad++; $display("[TB] FAIL stall_rsp_result: got %h want fffc0001", bus.rsp_result); end
            total++; if (bus.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_req_ready: got %b want 0", bus.req_ready); end
            total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL stall_busy: got %b want 1", busy); end
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL release_rsp_valid: got %b want 0", bus.rsp_valid); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_req_ready: got %b want 1", bus.req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL release_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_midop();
        int lat;
        logic [31:0] res;
        logic [31:0] mask;
        logic sawValid;
        sawValid = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_src1  = 32'h0001_0000;
        bus.req_src2  = 32'h0001_0000;
        bus.req_op    = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midop_busy: got %b want 1", busy); end
        reset_n = 1'b0;
        #1;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL midop_rsp_valid: got %b want 0", bus.rsp_valid); end
        total++; if (bus.rsp_result !== 32'h0) begin bad++; $display("[TB] FAIL midop_rsp_result: got %h want 0", bus.rsp_result); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midop_busy_clr: got %b want 0", busy); end
        total++; if (cell_en !== 1'b0) begin bad++; $display("[TB] FAIL midop_cell_en: got %b want 0", cell_en); end
        total++; if (cell_src1 !== 32'h0) begin bad++; $display("[TB] FAIL midop_cell_src1: got %h want 0", cell_src1); end
        total++; if (cell_src2 !== 32'h0) begin bad++; $display("[TB] FAIL midop_cell_src2: got %h want 0", cell_src2); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) sawValid = 1'b1;
        end
        total++; if (sawValid !== 1'b0) begin bad++; $display("[TB] FAIL midop_no_rsp: got %b want 0", sawValid); end
        runOp(32'h0000_0007, 32'h0000_0006, 1'b0, lat, res, mask);
        total++; if (res !== 32'h0000_002A) begin bad++; $display("[TB] FAIL after_reset_result: got %h want 0000002a", res); end
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL after_reset_latency: got %0d want 3", lat); end
    endtask

    task automatic test_back_to_back();
        int accepts[$];
        int resps[$];
        int wrongRes;
        wrongRes = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_src1  = 32'h0000_1234;
        bus.req_src2  = 32'h0000_0010;
        bus.req_op    = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.req_ready) accepts.push_back(c);
            if (bus.rsp_valid) begin
                resps.push_back(c);
                if (bus.rsp_result !== 32'h0001_2340) wrongRes++;
            end
        end
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        total++; if (accepts.size() !== 3) begin bad++; $display("[TB] FAIL b2b_accept_count: got %0d want 3", accepts.size()); end
        total++; if (accepts.size() < 2 || accepts[1] - accepts[0] !== 4) begin bad++; $display("[TB] FAIL b2b_interval: got %0d want 4", accepts.size() < 2 ? -1 : accepts[1] - accepts[0]); end
        total++; if (resps.size() !== 3) begin bad++; $display("[TB] FAIL b2b_resp_count: got %0d want 3", resps.size()); end
        total++; if (resps.size() < 1 || resps[0] !== 3) begin bad++; $display("[TB] FAIL b2b_first_resp: got %0d want 3", resps.size() < 1 ? -1 : resps[0]); end
        total++; if (wrongRes !== 0) begin bad++; $display("[TB] FAIL b2b_results: got %0d wrong want 0", wrongRes); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_mul_basic();
        test_all_ones();
        test_carry();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
